chain_latency_probe: RTL and testbench
======================================

# chain_latency_probe

Launch-and-capture controller for register-chain experiments. It drives a single-cycle pulse into the input of a synchronous register chain clocked by the same `clk`, watches the chain output, and reports the measured depth in clock cycles on `latency` and on the 8-bit `leds` bank. It is the transmit/receive counterpart of the N-register delay chain: its `probe_out` drives the chain's `in`, and the chain's `out` drives its `probe_in`.

## Interface
- `CNT_W`, default 16: width of the cycle counter and of `latency`.
- `MAX_WAIT`, default 1023: largest measurable latency in cycles; must be less than 2^CNT_W.
- `FLUSH_CYC`, default 300: number of quiet-check samples taken before launch; must be at least 1.
- `clk` in 1: single clock, shared with the chain under test.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `probe_in` in 1: chain output; same clock domain, not synchronized.
- `probe_out` out 1: pulse into the chain input.
- `busy` out 1: high from the start edge until the edge that raises `done`.
- `done` out 1: one-cycle pulse when results become valid.
- `latency` out CNT_W: measured depth; held until the next accepted start.
- `timeout` out 1: no pulse returned within `MAX_WAIT`.
- `err_stuck` out 1: `probe_in` was high during FLUSH.
- `err_width` out 1: returned pulse lasted longer than one cycle.
- `leds` out 8: `min(latency, 255)`; 0 when any error flag is set.

## Operation
- All outputs are registered.
- Reset values: every output is 0; state is IDLE; both counters are 0.
- State machine: IDLE → FLUSH → WAIT → TAIL → IDLE. FLUSH and WAIT may also return directly to IDLE on an error or timeout.
- IDLE:
  - `start`=1: set `busy`; clear `latency`, `timeout`, `err_stuck` and `err_width`; clear the flush counter `fcnt`; go to FLUSH.
  - `start` while busy is ignored.
- FLUSH (`probe_out`=0):
  - `probe_in`=1: set `err_stuck`, pulse `done`, clear `busy`, go to IDLE.
  - Else if `fcnt`==FLUSH_CYC-1: set `probe_out`, clear the cycle counter `cnt`, go to WAIT. This edge is the launch edge, E0.
  - Else increment `fcnt`.
- WAIT (`probe_out` is cleared at the first WAIT edge, giving a pulse exactly one cycle wide):
  - `probe_in`=1: `latency`<=`cnt`, go to TAIL.
  - Else if `cnt`==MAX_WAIT: set `timeout`, `latency`<=0, pulse `done`, clear `busy`, go to IDLE.
  - Else increment `cnt`.
- TAIL:
  - `probe_in`=1: set `err_width`.
  - Always: pulse `done`, clear `busy`, go to IDLE.
- Width rules:
  - `cnt` never exceeds MAX_WAIT, so there is no wrap-around.
  - `leds` saturates at 8'hFF for latency ≥ 255.
- A pulse still in flight from an aborted run is caught by FLUSH only if the chain depth is below FLUSH_CYC. Callers set FLUSH_CYC above the deepest chain (256).

## Timing
- Latency definition: number of rising edges from E0 to the edge at which `probe_in` is first seen high.
  - Direct wire gives 0.
  - An N-register chain gives N.
- With `start` sampled at edge S:
  - E0 = S + FLUSH_CYC.
  - `done` is high in the cycle after edge S + FLUSH_CYC + N + 2.
  - `busy` spans FLUSH_CYC + N + 2 cycles.
- Timeout: `done` follows edge S + FLUSH_CYC + MAX_WAIT + 1.
- Stuck input: `done` follows edge S + 1.
- Reset mid-operation:
  - At the reset edge, all outputs and state return to reset values.
  - `probe_out` is 0 from that edge.
  - No `done` is produced for the aborted run.
- `start` held high continuously: a new run begins on the edge after `done` (IDLE re-samples `start`).

## Test plan
- Wire loopback (`probe_in`=`probe_out`), FLUSH_CYC=4, pulse `start` → `done` after 6 cycles, `latency`=0, `leds`=0, all flags 0.
- Behavioural 256-register chain, default parameters → `latency`=256, `leds`=8'hFF, `done` exactly 558 cycles after the start edge, `err_width`=0.
- 5-register chain, FLUSH_CYC=4 → `latency`=5, `leds`=8'h05, `busy` high for 11 cycles; `start` pulses issued during `busy` are ignored.
- `probe_in` tied 0, MAX_WAIT=20, FLUSH_CYC=4 → `timeout`=1, `latency`=0, `done` after edge S+25.
- `probe_in` tied 1 → `err_stuck`=1, `done` in the cycle after S+1, `probe_out` never rises.
- Chain model that stretches the pulse to 2 cycles, depth 3 → `latency`=3, `err_width`=1, `leds`=0.
- Assert `rst` mid-WAIT → all outputs 0 on the next cycle; a following start gives a correct `latency`.

Source files
------------

// File: rtl/chain_latency_probe.sv
// Launch-and-capture controller: fires a one-cycle pulse into a register chain on
// the same clock and measures how many edges it takes to come back out.
module chain_latency_probe #(
    parameter int CNT_W     = 16,
    parameter int MAX_WAIT  = 1023,
    parameter int FLUSH_CYC = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             probe_in,
    output logic             probe_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] latency,
    output logic             timeout,
    output logic             err_stuck,
    output logic             err_width,
    output logic [7:0]       leds
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LED_SAT    = CNT_W'(255);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WAIT,
        ST_TAIL
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              probe_out_q, probe_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  latency_q, latency_d;
    logic              timeout_q, timeout_d;
    logic              err_stuck_q, err_stuck_d;
    logic              err_width_q, err_width_d;
    logic [7:0]        leds_q, leds_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            cnt_q       <= '0;
            probe_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            latency_q   <= '0;
            timeout_q   <= 1'b0;
            err_stuck_q <= 1'b0;
            err_width_q <= 1'b0;
            leds_q      <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
            probe_out_q <= probe_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            latency_q   <= latency_d;
            timeout_q   <= timeout_d;
            err_stuck_q <= err_stuck_d;
            err_width_q <= err_width_d;
            leds_q      <= leds_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        cnt_d       = cnt_q;
        probe_out_d = 1'b0;     // the launch pulse is exactly one cycle wide
        busy_d      = busy_q;
        done_d      = 1'b0;
        latency_d   = latency_q;
        timeout_d   = timeout_q;
        err_stuck_d = err_stuck_q;
        err_width_d = err_width_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    latency_d   = '0;
                    timeout_d   = 1'b0;
                    err_stuck_d = 1'b0;
                    err_width_d = 1'b0;
                    fcnt_d      = '0;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (probe_in) begin
                    err_stuck_d = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (fcnt_q == FLUSH_LAST) begin
                    probe_out_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end else begin
                    fcnt_d = fcnt_q + FC_W'(1);
                end
            end
            ST_WAIT: begin
                if (probe_in) begin
                    latency_d = cnt_q;
                    state_d   = ST_TAIL;
                end else if (cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    latency_d = '0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                // Still high one edge after capture means the pulse was stretched.
                if (probe_in) err_width_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_d || err_stuck_d || err_width_d)
            leds_d = 8'h00;
        else if (latency_d > LED_SAT)
            leds_d = 8'hFF;
        else
            leds_d = latency_d[7:0];
    end

    assign probe_out = probe_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign latency   = latency_q;
    assign timeout   = timeout_q;
    assign err_stuck = err_stuck_q;
    assign err_width = err_width_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_chain_latency_probe.sv
// Directed bench: a small-parameter probe against a selectable chain model, and a
// default-parameter probe against a 256-register chain.
module tb_chain_latency_probe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic start_a, start_b;
    logic probe_in_a, probe_out_a, busy_a, done_a, timeout_a, err_stuck_a, err_width_a;
    logic probe_in_b, probe_out_b, busy_b, done_b, timeout_b, err_stuck_b, err_width_b;
    logic [15:0] latency_a, latency_b;
    logic [7:0]  leds_a, leds_b;
    logic [7:0]  sh_a;
    logic [255:0] sh_b;

    assign start_a = start && !sel;
    assign start_b = start && sel;

    chain_latency_probe #(.CNT_W(16), .MAX_WAIT(20), .FLUSH_CYC(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .probe_in(probe_in_a),
        .probe_out(probe_out_a), .busy(busy_a), .done(done_a), .latency(latency_a),
        .timeout(timeout_a), .err_stuck(err_stuck_a), .err_width(err_width_a), .leds(leds_a)
    );

    chain_latency_probe dut_b (
        .clk(clk), .rst(rst), .start(start_b), .probe_in(probe_in_b),
        .probe_out(probe_out_b), .busy(busy_b), .done(done_b), .latency(latency_b),
        .timeout(timeout_b), .err_stuck(err_stuck_b), .err_width(err_width_b), .leds(leds_b)
    );

    // sh_a[k] is probe_out_a delayed by k+1 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
        end else begin
            sh_a <= {sh_a[6:0], probe_out_a};
            sh_b <= {sh_b[254:0], probe_out_b};
        end
    end

    assign probe_in_b = sh_b[255];

    always_comb begin
        probe_in_a = 1'b0;
        case (mode)
            0: probe_in_a = probe_out_a;
            1: probe_in_a = sh_a[4];
            2: probe_in_a = sh_a[2] | sh_a[3];
            3: probe_in_a = 1'b0;
            4: probe_in_a = 1'b1;
            default: probe_in_a = 1'b0;
        endcase
    end

    logic        m_busy, m_done, m_po;
    logic [15:0] m_lat;
    logic [7:0]  m_leds;
    logic [2:0]  m_flags;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_po    = sel ? probe_out_b : probe_out_a;
    assign m_lat   = sel ? latency_b : latency_a;
    assign m_leds  = sel ? leds_b : leds_a;
    assign m_flags = sel ? {timeout_b, err_stuck_b, err_width_b}
                         : {timeout_a, err_stuck_a, err_width_a};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; start is sampled on the next edge S.
    // done_at = k when done is first seen after edge S+k, -1 if never.
    task automatic measure(input int limit, input bit poke,
                           output int done_at, output int busy_cnt, output bit po_hi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = m_busy ? 1 : 0;
        po_hi = m_po;
        done_at = -1;
        for (int k = 1; k <= limit; k++) begin
            if (poke) start = (k == 2 || k == 5);
            @(posedge clk); #1;
            if (m_po) po_hi = 1'b1;
            if (m_busy) busy_cnt++;
            if (m_done) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int d, b;
    bit p;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst_ctl", {probe_out_a, busy_a, done_a, timeout_a, err_stuck_a, err_width_a}, 0);
        chk("rst_lat", latency_a, 0);
        chk("rst_leds", leds_a, 0);

        mode = 0;
        measure(50, 1'b0, d, b, p);
        chk("wire_done", d, 6);
        chk("wire_lat", m_lat, 0);
        chk("wire_leds", m_leds, 0);
        chk("wire_flags", m_flags, 0);
        idle(3);

        mode = 1;
        measure(50, 1'b1, d, b, p);
        chk("ch5_done", d, 11);
        chk("ch5_busy", b, 11);
        chk("ch5_lat", m_lat, 5);
        chk("ch5_leds", m_leds, 5);
        idle(2);
        chk("ch5_noretrig", m_busy, 0);
        idle(3);

        mode = 3;
        measure(60, 1'b0, d, b, p);
        chk("to_done", d, 25);
        chk("to_flags", m_flags, 3'b100);
        chk("to_lat", m_lat, 0);
        chk("to_leds", m_leds, 0);
        idle(3);

        mode = 4;
        measure(20, 1'b0, d, b, p);
        chk("stuck_done", d, 1);
        chk("stuck_flags", m_flags, 3'b010);
        chk("stuck_po", p, 0);
        idle(3);

        mode = 2;
        measure(50, 1'b0, d, b, p);
        chk("wid_done", d, 9);
        chk("wid_lat", m_lat, 3);
        chk("wid_flags", m_flags, 3'b001);
        chk("wid_leds", m_leds, 0);
        idle(3);

        // reset in the middle of WAIT: start at S, WAIT begins after S+4
        mode = 1;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(6);
        chk("mid_busy", busy_a, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_ctl", {probe_out_a, busy_a, done_a, timeout_a, err_stuck_a, err_width_a}, 0);
        chk("mid_lat_leds", {latency_a, leds_a}, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done_a) seen++;
            end
            chk("mid_nodone", seen, 0);
        end
        measure(50, 1'b0, d, b, p);
        chk("mid_re_done", d, 11);
        chk("mid_re_lat", m_lat, 5);
        idle(3);

        sel = 1'b1;
        measure(700, 1'b0, d, b, p);
        chk("c256_done", d, 558);
        chk("c256_busy", b, 558);
        chk("c256_lat", m_lat, 256);
        chk("c256_leds", m_leds, 255);
        chk("c256_flags", m_flags, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
